avalon_pio_gpio: RTL and testbench

Parametrised Avalon-MM general-purpose I/O slave: the successor to the team's fixed 2-bit output-only PIO. It provides WIDTH bidirectional pins with per-bit direction control, a two-flop input synchroniser, and edge-capture registers. It also has a maskable level interrupt. It sits on the Qsys/NIOS peripheral bus next to the HPI/OTG and game-control PIOs.

---
 rtl/avalon_pio_gpio_if.sv | 45 ++++
 rtl/avalon_pio_gpio.sv | 174 +++++++++++++++++
 tb/tb_avalon_pio_gpio.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_pio_gpio_if.sv
// ---------------------------------------------------------------------------
// avalon_pio_gpio_if
//
// Avalon-MM slave bus bundle for the avalon_pio_gpio peripheral.
//
// Handshake: there is no waitrequest. A write is accepted on every clk edge
// where chipselect is high and write_n is low. A read is accepted on every
// clk edge where chipselect is high and read_n is low, and readdata is valid
// from that edge onward (fixed 1-cycle latency). Issuing a read and a write
// in the same cycle is not a legal bus operation.
//
// Signals:
//   address    [2:0]   register select            (master -> slave)
//   chipselect         slave select               (master -> slave)
//   read_n             active-low read strobe     (master -> slave)
//   write_n            active-low write strobe    (master -> slave)
//   writedata  [31:0]  write data                 (master -> slave)
//   readdata   [31:0]  registered read data       (slave -> master)
// ---------------------------------------------------------------------------
interface avalon_pio_gpio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output read_n,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  read_n,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/avalon_pio_gpio.sv
// ---------------------------------------------------------------------------
// avalon_pio_gpio
//
// Parametrised Avalon-MM GPIO slave: WIDTH bidirectional pins with per-bit
// direction, a two-flop input synchroniser, edge-capture registers and a
// maskable level interrupt.
//
// Optional feature macro: PIO_BITSET_EN
//   defined   -> address 4 (OUTSET) and 5 (OUTCLR) give atomic per-bit
//                set/clear of the output data register.
//   undefined -> addresses 4 and 5 read 0 and ignore writes.
//
// Register map (address):
//   0 DATA     read: per bit, dir ? data_out : sync2 ; write: data_out
//   1 DIR      read/write, 1 = output
//   2 IRQMASK  read/write
//   3 EDGECAP  read captured edges ; write 1 to clear
//   4 OUTSET   (PIO_BITSET_EN) data_out |= wd, reads 0
//   5 OUTCLR   (PIO_BITSET_EN) data_out &= ~wd, reads 0
//   6,7        read 0, writes ignored
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   bus       Avalon-MM slave (address, chipselect, read_n, write_n,
//             writedata, readdata)
//   in_port   pad inputs, asynchronous to clk
//   out_port  pad output data (data_out)
//   out_oe    per-bit output enable (dir)
//   irq       level interrupt, |(edgecap & irqmask)
// ---------------------------------------------------------------------------
module avalon_pio_gpio #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               EDGE_TYPE   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    avalon_pio_gpio_if.slave     bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic [WIDTH-1:0]     out_port,
    output logic [WIDTH-1:0]     out_oe,
    output logic                 irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
`ifdef PIO_BITSET_EN
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
`endif

    // Architectural state
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [31:0]      readdata_q;

    // Bus decode
    logic             wr_strobe;
    logic             rd_strobe;
    logic [WIDTH-1:0] wd;

    assign wr_strobe = bus.chipselect && !bus.write_n;
    assign rd_strobe = bus.chipselect && !bus.read_n;
    assign wd        = bus.writedata[WIDTH-1:0];

    // Bits of writedata above WIDTH are deliberately dropped.
    logic unused_writedata;
    assign unused_writedata = &{1'b0, bus.writedata};

    // Edge detection between the synchronised sample and its previous value
    logic [WIDTH-1:0] edge_det;

    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == 0) begin
            edge_det = sync2 & ~prev;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~sync2 & prev;
        end else begin
            edge_det = sync2 ^ prev;
        end
    end

    // Write-1-to-clear mask for EDGECAP
    logic [WIDTH-1:0] edge_clr;

    always_comb begin
        edge_clr = '0;
        if (wr_strobe && bus.address == ADDR_EDGECAP) begin
            edge_clr = wd;
        end
    end

    // Next output data: full load, or atomic set/clear when enabled
    logic [WIDTH-1:0] data_next;

    always_comb begin
        data_next = data_out;
        if (wr_strobe) begin
            if (bus.address == ADDR_DATA) begin
                data_next = wd;
            end
`ifdef PIO_BITSET_EN
            else if (bus.address == ADDR_OUTSET) begin
                data_next = data_out | wd;
            end else if (bus.address == ADDR_OUTCLR) begin
                data_next = data_out & ~wd;
            end
`endif
        end
    end

    // Read mux; unused upper bits and unmapped addresses return 0
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = (dir & data_out) | (~dir & sync2);
            ADDR_DIR:     rd_mux[WIDTH-1:0] = dir;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out   <= RESET_VALUE;
            dir        <= DIR_RESET;
            irqmask    <= '0;
            edgecap    <= '0;
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            readdata_q <= '0;
        end else begin
            data_out <= data_next;

            if (wr_strobe && bus.address == ADDR_DIR) begin
                dir <= wd;
            end
            if (wr_strobe && bus.address == ADDR_IRQMASK) begin
                irqmask <= wd;
            end

            // A new edge overrides a simultaneous clear of the same bit.
            edgecap <= (edgecap & ~edge_clr) | edge_det;

            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;

            if (rd_strobe) begin
                readdata_q <= rd_mux;
            end
        end
    end

    assign bus.readdata = readdata_q;
    assign out_port     = data_out;
    assign out_oe       = dir;
    assign irq          = |(edgecap & irqmask);

endmodule

// File: tb/tb_avalon_pio_gpio.sv
// ---------------------------------------------------------------------------
// tb_avalon_pio_gpio
//
// Directed bench for avalon_pio_gpio with WIDTH=8, RESET_VALUE=8'hA5,
// DIR_RESET=8'h0F, EDGE_TYPE=0 (rising). Bus inputs change on the falling
// clock edge; outputs are sampled on the falling edge or between edges.
// Set/clear expectations follow PIO_BITSET_EN.
// ---------------------------------------------------------------------------
module tb_avalon_pio_gpio;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_port;
    logic [WIDTH-1:0] out_port;
    logic [WIDTH-1:0] out_oe;
    logic             irq;

    avalon_pio_gpio_if bus ();

    avalon_pio_gpio #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (8'hA5),
        .DIR_RESET   (8'h0F),
        .EDGE_TYPE   (0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .in_port  (in_port),
        .out_port (out_port),
        .out_oe   (out_oe),
        .irq      (irq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
    endtask

    // Strobe is sampled by the posedge inside this task; returns on the
    // following negedge, when the write is visible.
    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        @(negedge clk);
        bus_idle();
        data = bus.readdata;
    endtask

    task automatic read_expect(input string tag, input logic [2:0] addr,
                               input logic [31:0] exp);
        logic [31:0] rd;
        exp_q.push_back(exp);
        bus_read(addr, rd);
        check(tag, rd, exp_q.pop_front());
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    logic [7:0] exp_outset;
    logic [7:0] exp_outclr;

    // ---------------- stimulus ----------------
    initial begin
        bus_idle();
        in_port = '0;
        reset   = 1'b1;
        wait_cycles(3);
        reset = 1'b0;

        // Reset state
        check("rst_out_port", 32'(out_port), 32'hA5);
        check("rst_out_oe",   32'(out_oe),   32'h0F);
        check("rst_irq",      32'(irq),      32'h0);
        read_expect("rst_data",    3'd0, 32'h0000_0005);
        read_expect("rst_dir",     3'd1, 32'h0000_000F);
        read_expect("rst_irqmask", 3'd2, 32'h0);
        read_expect("rst_edgecap", 3'd3, 32'h0);
        read_expect("rst_addr4",   3'd4, 32'h0);
        read_expect("rst_addr5",   3'd5, 32'h0);
        read_expect("rst_addr6",   3'd6, 32'h0);
        read_expect("rst_addr7",   3'd7, 32'h0);

        // Output path
        bus_write(3'd1, 32'h0000_00FF);
        check("dir_oe", 32'(out_oe), 32'hFF);
        bus_write(3'd0, 32'h0000_003C);
        check("data_out_port", 32'(out_port), 32'h3C);
        read_expect("data_read_out", 3'd0, 32'h0000_003C);
        bus_write(3'd0, 32'hFFFF_FF12);
        read_expect("data_upper_ignored", 3'd0, 32'h0000_0012);
        bus_write(3'd6, 32'h0000_0077);
        check("addr6_write_ignored", 32'(out_port), 32'h12);

        // Rising-edge capture on bit 0
        bus_write(3'd1, 32'h0);
        bus_write(3'd2, 32'h0000_0001);
        @(negedge clk);
        in_port = 8'h01;
        @(negedge clk);                     // after N
        check("edge_irq_n0", 32'(irq), 32'h0);
        @(negedge clk);                     // after N+1
        check("edge_irq_n1", 32'(irq), 32'h0);
        @(negedge clk);                     // after N+2
        check("edge_irq_n2", 32'(irq), 32'h1);
        read_expect("edgecap_set",  3'd3, 32'h0000_0001);
        read_expect("data_read_in", 3'd0, 32'h0000_0001);
        bus_write(3'd3, 32'h0000_0001);
        check("clr_irq", 32'(irq), 32'h0);

        // Falling edge does not capture
        in_port = 8'h00;
        wait_cycles(4);
        read_expect("fall_no_cap", 3'd3, 32'h0);
        check("fall_irq", 32'(irq), 32'h0);

        // Unmasked edge: captured but no irq
        in_port = 8'h08;
        wait_cycles(4);
        read_expect("bit3_cap", 3'd3, 32'h0000_0008);
        check("bit3_no_irq", 32'(irq), 32'h0);
        bus_write(3'd3, 32'h0000_00FF);
        read_expect("bit3_cleared", 3'd3, 32'h0);

        // Clear of bit 0 in the same cycle its new edge lands: set wins
        in_port = 8'h00;
        wait_cycles(3);
        @(negedge clk);
        in_port = 8'h01;                    // before N
        @(negedge clk);                     // after N
        bus_write(3'd3, 32'h0000_0001);     // strobe sampled at N+2
        check("setwins_irq", 32'(irq), 32'h1);
        read_expect("setwins_edgecap", 3'd3, 32'h0000_0001);

        // Set / clear registers
        bus_write(3'd1, 32'h0000_00FF);
        bus_write(3'd0, 32'h0000_00F0);
`ifdef PIO_BITSET_EN
        exp_outset = 8'hF3;
        exp_outclr = 8'hE3;
`else
        exp_outset = 8'hF0;
        exp_outclr = 8'hF0;
`endif
        bus_write(3'd4, 32'h0000_0003);
        check("outset", 32'(out_port), 32'(exp_outset));
        bus_write(3'd5, 32'h0000_0010);
        check("outclr", 32'(out_port), 32'(exp_outclr));
        read_expect("outset_reads0", 3'd4, 32'h0);
        read_expect("outclr_reads0", 3'd5, 32'h0);

        // Fill EDGECAP and raise irq, then reset asynchronously
        in_port = 8'h00;
        wait_cycles(4);
        bus_write(3'd3, 32'h0000_00FF);
        bus_write(3'd2, 32'h0000_00FF);
        in_port = 8'hFF;
        wait_cycles(4);
        read_expect("full_edgecap", 3'd3, 32'h0000_00FF);
        check("full_irq", 32'(irq), 32'h1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;                                 // still before the next posedge
        check("async_out_port", 32'(out_port), 32'hA5);
        check("async_out_oe",   32'(out_oe),   32'h0F);
        check("async_irq",      32'(irq),      32'h0);
        @(negedge clk);
        reset = 1'b0;
        read_expect("post_rst_irqmask", 3'd2, 32'h0);
        read_expect("post_rst_dir",     3'd1, 32'h0000_000F);
        // Pin held high through reset gives one rising edge on every bit
        wait_cycles(3);
        read_expect("post_rst_edgecap", 3'd3, 32'h0000_00FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
